// File: rtl/imem_boot_ctrl.sv
// Boot loader and port arbiter for the instruction memory: streams a program into
// consecutive words until the end marker, pulses start, then hands the port to fetch.
module imem_boot_ctrl #(
    parameter int                 cXLEN      = 32,
    parameter int                 cDepthLog2 = 10,
    parameter logic [cXLEN-1:0]   cEndMarker = 32'hDEADBEAF
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic [cXLEN-1:0]      iInst,
    input  logic                  iInstValid,
    output logic                  oInstReady,
    input  logic                  iReload,
    input  logic                  iFetchReq,
    input  logic [cDepthLog2-1:0] iFetchAddr,
    output logic                  oFetchGnt,
    output logic [cDepthLog2-1:0] oMemAddr,
    output logic [cXLEN-1:0]      oMemWdata,
    output logic                  oMemWen,
    output logic                  oStart,
    output logic                  oRunning,
    output logic [cDepthLog2:0]   oLoadCount,
    output logic                  oOverflow
);

    typedef enum logic [1:0] {
        LOAD,
        START,
        RUN,
        ERR
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [cDepthLog2:0]     load_count;
    logic [cDepthLog2:0]     next_count;
    logic [cDepthLog2-1:0]   mem_addr;
    logic [cDepthLog2-1:0]   next_addr;
    logic [cXLEN-1:0]        mem_wdata;
    logic [cXLEN-1:0]        next_wdata;
    logic                    mem_wen;
    logic                    next_wen;
    logic                    fetch_gnt;
    logic                    next_gnt;
    logic                    start;
    logic                    next_start;
    logic                    overflow;
    logic                    next_overflow;
    logic                    accept;
    logic                    is_marker;
    logic                    full;

    assign accept    = iInstValid && (state == LOAD);
    assign is_marker = (iInst == cEndMarker);
    // The count's top bit set means every word of the memory already holds program.
    assign full      = load_count[cDepthLog2];

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state      <= LOAD;
            load_count <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wen    <= 1'b0;
            fetch_gnt  <= 1'b0;
            start      <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= next_state;
            load_count <= next_count;
            mem_addr   <= next_addr;
            mem_wdata  <= next_wdata;
            mem_wen    <= next_wen;
            fetch_gnt  <= next_gnt;
            start      <= next_start;
            overflow   <= next_overflow;
        end
    end

    // Reload beats everything, including a word accepted on the same edge.
    always_comb begin
        next_state    = state;
        next_count    = load_count;
        next_addr     = mem_addr;
        next_wdata    = mem_wdata;
        next_wen      = 1'b0;
        next_gnt      = 1'b0;
        next_start    = 1'b0;
        next_overflow = overflow;
        if (iReload) begin
            next_state    = LOAD;
            next_count    = '0;
            next_overflow = 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (!is_marker) begin
                            if (!full) begin
                                next_wen   = 1'b1;
                                next_addr  = load_count[cDepthLog2-1:0];
                                next_wdata = iInst;
                                next_count = load_count + 1'b1;
                            end else begin
                                next_state    = ERR;
                                next_overflow = 1'b1;
                            end
                        end else if (load_count != '0) begin
                            next_state = START;
                            next_start = 1'b1;
                        end
                    end
                end
                START: begin
                    next_state = RUN;
                end
                RUN: begin
                    next_addr = iFetchAddr;
                    next_gnt  = iFetchReq;
                end
                ERR: begin
                    next_overflow = 1'b1;
                end
                default: begin
                    next_state = LOAD;
                end
            endcase
        end
    end

    assign oInstReady = (state == LOAD);
    assign oRunning   = (state == RUN);
    assign oLoadCount = load_count;
    assign oMemAddr   = mem_addr;
    assign oMemWdata  = mem_wdata;
    assign oMemWen    = mem_wen;
    assign oFetchGnt  = fetch_gnt;
    assign oStart     = start;
    assign oOverflow  = overflow;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: per-cycle vector table plus a write scoreboard,
// and a small-depth instance for the overflow path.
module tb_imem_boot_ctrl;

    localparam logic [31:0] MARK = 32'hDEADBEAF;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic [31:0] inst;
    logic        inst_valid;
    logic        reload;
    logic        fetch_req;
    logic [9:0]  fetch_addr;
    logic        inst_ready;
    logic        fetch_gnt;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic        start;
    logic        running;
    logic [10:0] load_count;
    logic        overflow;

    logic [31:0] s_inst;
    logic        s_valid;
    logic        s_reload;
    logic        s_ready;
    logic        s_gnt;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic        s_wen;
    logic        s_start;
    logic        s_running;
    logic [2:0]  s_count;
    logic        s_overflow;

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        logic        valid;
        logic [31:0] inst;
        logic        reload;
        logic        freq;
        logic [9:0]  faddr;
        logic        wr;
        logic [9:0]  wr_addr;
        logic        rdy;
        logic        st;
        logic        run;
        logic        gnt;
        logic [10:0] cnt;
    } vec_t;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    vec_t vecs[$];
    wr_t  exp_q[$];

    always #5 iClk = ~iClk;

    imem_boot_ctrl dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iInst      (inst),
        .iInstValid (inst_valid),
        .oInstReady (inst_ready),
        .iReload    (reload),
        .iFetchReq  (fetch_req),
        .iFetchAddr (fetch_addr),
        .oFetchGnt  (fetch_gnt),
        .oMemAddr   (mem_addr),
        .oMemWdata  (mem_wdata),
        .oMemWen    (mem_wen),
        .oStart     (start),
        .oRunning   (running),
        .oLoadCount (load_count),
        .oOverflow  (overflow)
    );

    imem_boot_ctrl #(.cDepthLog2(2)) dut_small (
        .iClk       (iClk),
        .iRst       (iRst),
        .iInst      (s_inst),
        .iInstValid (s_valid),
        .oInstReady (s_ready),
        .iReload    (s_reload),
        .iFetchReq  (1'b0),
        .iFetchAddr (2'b00),
        .oFetchGnt  (s_gnt),
        .oMemAddr   (s_addr),
        .oMemWdata  (s_wdata),
        .oMemWen    (s_wen),
        .oStart     (s_start),
        .oRunning   (s_running),
        .oLoadCount (s_count),
        .oOverflow  (s_overflow)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    function automatic vec_t mk(input logic valid, input logic [31:0] w, input logic rl,
                                input logic freq, input logic [9:0] faddr, input logic wr,
                                input logic [9:0] wa, input logic rdy, input logic st,
                                input logic run, input logic gnt, input logic [10:0] cnt);
        vec_t v;
        v.valid = valid; v.inst = w; v.reload = rl; v.freq = freq; v.faddr = faddr;
        v.wr = wr; v.wr_addr = wa; v.rdy = rdy; v.st = st; v.run = run; v.gnt = gnt; v.cnt = cnt;
        return v;
    endfunction

    task automatic check_reset_values();
        check_output("rst_ready",    {31'd0, inst_ready}, 32'd1);
        check_output("rst_count",    {21'd0, load_count}, 32'd0);
        check_output("rst_addr",     {22'd0, mem_addr},   32'd0);
        check_output("rst_wdata",    mem_wdata,           32'd0);
        check_output("rst_wen",      {31'd0, mem_wen},    32'd0);
        check_output("rst_gnt",      {31'd0, fetch_gnt},  32'd0);
        check_output("rst_start",    {31'd0, start},      32'd0);
        check_output("rst_running",  {31'd0, running},    32'd0);
        check_output("rst_overflow", {31'd0, overflow},   32'd0);
    endtask

    // Expected writes are queued as the word is driven and retired by the monitor below.
    task automatic apply_stimulus(input vec_t v);
        wr_t e;
        inst       = v.inst;
        inst_valid = v.valid;
        reload     = v.reload;
        fetch_req  = v.freq;
        fetch_addr = v.faddr;
        if (v.wr) begin
            e.addr = v.wr_addr;
            e.data = v.inst;
            exp_q.push_back(e);
        end
        @(posedge iClk);
        #1;
        check_output("ready",   {31'd0, inst_ready}, {31'd0, v.rdy});
        check_output("start",   {31'd0, start},      {31'd0, v.st});
        check_output("running", {31'd0, running},    {31'd0, v.run});
        check_output("gnt",     {31'd0, fetch_gnt},  {31'd0, v.gnt});
        check_output("count",   {21'd0, load_count}, {21'd0, v.cnt});
        check_output("wen",     {31'd0, mem_wen},    {31'd0, v.wr});
        if (v.freq && v.gnt) begin
            check_output("fetch_addr", {22'd0, mem_addr}, {22'd0, v.faddr});
        end
    endtask

    always @(negedge iClk) begin
        wr_t e;
        if (!iRst && mem_wen) begin
            if (exp_q.size() == 0) begin
                checks_total++;
                $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check_output("wr_addr", {22'd0, mem_addr}, {22'd0, e.addr});
                check_output("wr_data", mem_wdata, e.data);
            end
        end
    end

    initial begin
        inst = '0; inst_valid = 1'b0; reload = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
        s_inst = '0; s_valid = 1'b0; s_reload = 1'b0;

        // normal load, fetch arbitration, reload in RUN with a valid word
        vecs.push_back(mk(1, 32'h00500093, 0, 1, 10'd5, 1, 10'd0, 1, 0, 0, 0, 11'd1));
        vecs.push_back(mk(1, 32'h00A00113, 0, 0, 10'd0, 1, 10'd1, 1, 0, 0, 0, 11'd2));
        vecs.push_back(mk(1, 32'h002081B3, 0, 0, 10'd0, 1, 10'd2, 1, 0, 0, 0, 11'd3));
        vecs.push_back(mk(1, MARK,         0, 0, 10'd0, 0, 10'd0, 0, 1, 0, 0, 11'd3));
        vecs.push_back(mk(0, 32'h0,        0, 0, 10'd0, 0, 10'd0, 0, 0, 1, 0, 11'd3));
        vecs.push_back(mk(1, 32'h12345678, 0, 1, 10'd7, 0, 10'd0, 0, 0, 1, 1, 11'd3));
        vecs.push_back(mk(0, 32'h0,        0, 0, 10'd0, 0, 10'd0, 0, 0, 1, 0, 11'd3));
        vecs.push_back(mk(1, 32'hCAFEF00D, 1, 0, 10'd0, 0, 10'd0, 1, 0, 0, 0, 11'd0));
        // same program with two idle cycles between words
        vecs.push_back(mk(1, 32'h00500093, 0, 0, 10'd0, 1, 10'd0, 1, 0, 0, 0, 11'd1));
        vecs.push_back(mk(0, 32'h0,        0, 0, 10'd0, 0, 10'd0, 1, 0, 0, 0, 11'd1));
        vecs.push_back(mk(0, 32'h0,        0, 0, 10'd0, 0, 10'd0, 1, 0, 0, 0, 11'd1));
        vecs.push_back(mk(1, 32'h00A00113, 0, 0, 10'd0, 1, 10'd1, 1, 0, 0, 0, 11'd2));
        vecs.push_back(mk(0, 32'h0,        0, 0, 10'd0, 0, 10'd0, 1, 0, 0, 0, 11'd2));
        vecs.push_back(mk(0, 32'h0,        0, 0, 10'd0, 0, 10'd0, 1, 0, 0, 0, 11'd2));
        vecs.push_back(mk(1, 32'h002081B3, 0, 0, 10'd0, 1, 10'd2, 1, 0, 0, 0, 11'd3));
        vecs.push_back(mk(0, 32'h0,        0, 0, 10'd0, 0, 10'd0, 1, 0, 0, 0, 11'd3));
        vecs.push_back(mk(0, 32'h0,        0, 0, 10'd0, 0, 10'd0, 1, 0, 0, 0, 11'd3));
        vecs.push_back(mk(1, MARK,         0, 0, 10'd0, 0, 10'd0, 0, 1, 0, 0, 11'd3));
        vecs.push_back(mk(0, 32'h0,        0, 0, 10'd0, 0, 10'd0, 0, 0, 1, 0, 11'd3));
        vecs.push_back(mk(0, 32'h0,        1, 0, 10'd0, 0, 10'd0, 1, 0, 0, 0, 11'd0));
        // leading marker is ignored
        vecs.push_back(mk(1, MARK,         0, 0, 10'd0, 0, 10'd0, 1, 0, 0, 0, 11'd0));
        vecs.push_back(mk(1, 32'h00000013, 0, 0, 10'd0, 1, 10'd0, 1, 0, 0, 0, 11'd1));
        vecs.push_back(mk(1, MARK,         0, 0, 10'd0, 0, 10'd0, 0, 1, 0, 0, 11'd1));
        vecs.push_back(mk(0, 32'h0,        0, 0, 10'd0, 0, 10'd0, 0, 0, 1, 0, 11'd1));
        vecs.push_back(mk(0, 32'h0,        1, 0, 10'd0, 0, 10'd0, 1, 0, 0, 0, 11'd0));
        // reload during LOAD drops the coincident word and restarts at address 0
        vecs.push_back(mk(1, 32'hAAAA0001, 0, 0, 10'd0, 1, 10'd0, 1, 0, 0, 0, 11'd1));
        vecs.push_back(mk(1, 32'hBBBB0002, 1, 0, 10'd0, 0, 10'd0, 1, 0, 0, 0, 11'd0));
        vecs.push_back(mk(1, 32'hCCCC0003, 0, 0, 10'd0, 1, 10'd0, 1, 0, 0, 0, 11'd1));
        vecs.push_back(mk(1, 32'hDDDD0004, 0, 0, 10'd0, 1, 10'd1, 1, 0, 0, 0, 11'd2));

        #1;
        check_reset_values();
        @(negedge iClk);
        iRst = 1'b0;

        foreach (vecs[i]) apply_stimulus(vecs[i]);

        // asynchronous reset in the middle of a load, away from any clock edge
        @(negedge iClk);
        #1;
        iRst = 1'b1;
        #1;
        check_reset_values();
        #1;
        iRst = 1'b0;
        apply_stimulus(mk(1, 32'h0000ABCD, 0, 0, 10'd0, 1, 10'd0, 1, 0, 0, 0, 11'd1));
        apply_stimulus(mk(0, 32'h0,        0, 0, 10'd0, 0, 10'd0, 1, 0, 0, 0, 11'd1));

        // overflow on the four-word instance
        for (int i = 0; i < 5; i++) begin
            s_inst  = 32'h100 + i;
            s_valid = 1'b1;
            @(posedge iClk);
            #1;
            if (i < 4) begin
                check_output("ovf_wen",   {31'd0, s_wen},   32'd1);
                check_output("ovf_addr",  {30'd0, s_addr},  i);
                check_output("ovf_data",  s_wdata,          32'h100 + i);
                check_output("ovf_count", {29'd0, s_count}, i + 1);
            end else begin
                check_output("ovf_last_wen", {31'd0, s_wen},      32'd0);
                check_output("ovf_flag",     {31'd0, s_overflow}, 32'd1);
                check_output("ovf_ready",    {31'd0, s_ready},    32'd0);
                check_output("ovf_count4",   {29'd0, s_count},    32'd4);
            end
        end
        s_inst = 32'h200;
        @(posedge iClk);
        #1;
        check_output("err_sticky",  {31'd0, s_overflow}, 32'd1);
        check_output("err_wen",     {31'd0, s_wen},      32'd0);
        check_output("err_gnt",     {31'd0, s_gnt},      32'd0);
        check_output("err_start",   {31'd0, s_start},    32'd0);
        check_output("err_running", {31'd0, s_running},  32'd0);
        s_valid  = 1'b0;
        s_reload = 1'b1;
        @(posedge iClk);
        #1;
        check_output("rl_overflow", {31'd0, s_overflow}, 32'd0);
        check_output("rl_count",    {29'd0, s_count},    32'd0);
        check_output("rl_ready",    {31'd0, s_ready},    32'd1);
        s_reload = 1'b0;
        s_valid  = 1'b1;
        s_inst   = 32'h300;
        @(posedge iClk);
        #1;
        check_output("rl_wen",  {31'd0, s_wen},  32'd1);
        check_output("rl_addr", {30'd0, s_addr}, 32'd0);
        check_output("rl_data", s_wdata,         32'h300);
        s_valid = 1'b0;

        @(negedge iClk);
        check_output("pending_writes", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot sequencer and port arbiter for the core's instruction memory. After reset it accepts a stream of instruction words over a valid/ready handshake and writes them to consecutive word addresses. The stream ends with the marker word `0xDEADBEAF`; the block then pulses the core start signal and hands the single memory port to the core fetch unit. A reload request returns the block to loading, so the bench or a debug host can load a new program without a reset.

## Interface
Parameters:
- cXLEN, 32, instruction/data word width
- cDepthLog2, 10, log2 of instruction memory depth in words
- cEndMarker, 32'hDEADBEAF, end-of-program marker word

Ports:
- iClk  in  1  clock; all state changes on the rising edge
- iRst  in  1  reset, asynchronous, active-high
- iInst  in  cXLEN  instruction word to load
- iInstValid  in  1  iInst is valid
- oInstReady  out  1  block accepts a word; combinational, equals (state==LOAD)
- iReload  in  1  request to abandon the current program and restart loading
- iFetchReq  in  1  core fetch request
- iFetchAddr  in  cDepthLog2  core fetch word address
- oFetchGnt  out  1  fetch request granted, registered
- oMemAddr  out  cDepthLog2  memory word address, registered
- oMemWdata  out  cXLEN  memory write data, registered
- oMemWen  out  1  memory write enable, registered
- oStart  out  1  one-cycle core start pulse, registered
- oRunning  out  1  high in RUN
- oLoadCount  out  cDepthLog2+1  number of words written since the last (re)load
- oOverflow  out  1  sticky program-too-large error

## Operation
- Handshake: a word is accepted on any edge where iInstValid && oInstReady. A word that is not accepted is not consumed.
- States and transitions:
  - LOAD (reset state):
    - Accepted word != cEndMarker and oLoadCount < 2^cDepthLog2: write the word at address oLoadCount[cDepthLog2-1:0], then oLoadCount++.
    - Accepted non-marker word with oLoadCount == 2^cDepthLog2: no write; go to ERR and set oOverflow.
    - Accepted marker with oLoadCount > 0: no write; go to START.
    - Accepted marker with oLoadCount == 0: discard it and stay in LOAD.
  - START: lasts exactly one cycle with oStart=1, then go to RUN.
  - RUN: each cycle, oMemAddr<=iFetchAddr, oMemWen<=0 and oFetchGnt<=iFetchReq. Incoming words are not accepted.
  - ERR: oOverflow=1, no memory writes, no grants. Left only by iReload or reset.
- iReload, sampled in any state, takes priority over every other event. Next state is LOAD with oLoadCount=0, oOverflow=0 and oStart=0. A word accepted on the same edge as iReload is dropped and not written.
- oFetchGnt is 0 in every state except RUN, so the loader and the core never drive the port together.
- oMemWen is 0 in every state except LOAD, and only in the cycle after an accepted non-marker word.
- Reset values: state=LOAD, oInstReady=1, oLoadCount=0, oMemAddr=0, oMemWdata=0, oMemWen=0, oFetchGnt=0, oStart=0, oRunning=0, oOverflow=0.
- An asynchronous reset in any state (including mid-load and RUN) immediately forces these values. Any partially loaded program is abandoned.

## Timing
- Write latency: word accepted at edge N → oMemWen=1 with oMemAddr/oMemWdata valid during cycle N+1. Back-to-back accepted words give back-to-back writes.
- Marker accepted at edge N → oStart=1 during cycle N+1 → oRunning=1 from cycle N+2.
- Fetch: iFetchReq sampled at edge N in RUN → oFetchGnt and oMemAddr valid during cycle N+1.
- iReload at edge N → oInstReady=1 and oRunning=0 during cycle N+1.
- Overflow: the offending word accepted at edge N → oOverflow=1 and oInstReady=0 from cycle N+1.

## Test plan
- Normal load: feed 0x00500093, 0x00A00113, 0x002081B3 and then the marker. Expect:
  - writes at addresses 0, 1, 2 in consecutive cycles;
  - oLoadCount=3;
  - one oStart pulse one cycle after the marker;
  - oRunning from the next cycle.
- Valid gaps: the same program with iInstValid low for 2 cycles between words. Expect:
  - identical addresses and data;
  - no write in the idle cycles.
- Marker first: feed the marker, then 0x00000013, then the marker. Expect:
  - the first marker is ignored;
  - one write at address 0;
  - oStart after the second marker.
- Overflow: with cDepthLog2=2, feed 5 non-marker words. Expect:
  - addresses 0..3 written;
  - the 5th word is not written;
  - oOverflow=1, oInstReady=0;
  - iReload clears oOverflow and oLoadCount.
- Fetch arbitration: in LOAD, iFetchReq=1 → oFetchGnt stays 0. In RUN, iFetchReq=1 with iFetchAddr=7 → next cycle oFetchGnt=1, oMemAddr=7, oMemWen=0.
- Reset and reload: assert iRst mid-load after 2 words → all outputs take their reset values with no clock edge, and loading restarts at address 0. Then assert iReload in RUN together with a valid word → the word is dropped, and the block returns to LOAD with oLoadCount=0 and oRunning=0.
